burst_wrr_arb: RTL and testbench

BURST_WRR_ARB -- requirements
Module: burst_wrr_arb

---
 rtl/burst_wrr_pkg.sv | 10 +
 rtl/lzc.sv | 35 +++
 rtl/burst_wrr_arb.sv | 171 +++++++++++++++++
 tb/tb_burst_wrr_arb.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_wrr_pkg.sv
// Shared types for the burst-aware weighted round-robin arbiter.
// Holds the arbiter state encoding used by burst_wrr_arb.
package burst_wrr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter with an empty flag.
// Ports: vec (input bits), cnt (position/count), empty (no bit set).
module lzc #(
  parameter int unsigned Width    = 4,
  parameter bit          Mode     = 1'b0,
  parameter int unsigned CntWidth = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0]    vec,
  output logic [CntWidth-1:0] cnt,
  output logic                empty
);

  always_comb begin
    cnt   = '0;
    empty = 1'b1;
    if (!Mode) begin
      // Scan downward so the lowest set bit wins.
      for (int i = Width - 1; i >= 0; i--) begin
        if (vec[i]) begin
          cnt   = CntWidth'(i);
          empty = 1'b0;
        end
      end
    end else begin
      // Scan upward so the highest set bit wins.
      for (int i = 0; i < Width; i++) begin
        if (vec[i]) begin
          cnt   = CntWidth'(Width - 1 - i);
          empty = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/burst_wrr_arb.sv
// Burst-locking weighted round-robin arbiter, NumIn requesters to one sink.
// Ports: clk_i/rst_ni/clr_i, weight_i, req_i/last_i/data_i/gnt_o upstream,
// req_o/last_o/data_o/idx_o/gnt_i downstream, busy_o while a burst is locked.
module burst_wrr_arb
  import burst_wrr_pkg::*;
#(
  parameter int unsigned NumIn       = 4,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned WeightWidth = 4,
  parameter type         DataType    = logic [DataWidth-1:0],
  // Derived; leave at default.
  parameter int unsigned IdxWidth    = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                clr_i,
  input  logic [NumIn-1:0][WeightWidth-1:0]   weight_i,
  input  logic [NumIn-1:0]                    req_i,
  input  logic [NumIn-1:0]                    last_i,
  input  DataType                             data_i [NumIn],
  output logic [NumIn-1:0]                    gnt_o,
  output logic                                req_o,
  output logic                                last_o,
  output DataType                             data_o,
  output logic [IdxWidth-1:0]                 idx_o,
  input  logic                                gnt_i,
  output logic                                busy_o
);

  state_e                 state_q, state_d;
  logic [IdxWidth-1:0]    ptr_q, ptr_d;
  logic [IdxWidth-1:0]    owner_q, owner_d;
  logic [IdxWidth-1:0]    lock_idx_q, lock_idx_d;
  logic                   lock_q, lock_d;
  logic [WeightWidth-1:0] credit_q, credit_d;
  logic [WeightWidth-1:0] wgt, eff_credit;

  logic [NumIn-1:0]       mask;
  logic [IdxWidth-1:0]    m_idx, f_idx, sel, idx;
  logic                   m_empty, f_empty;
  logic                   hs, lhs;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NumIn; i++) begin
      mask[i] = req_i[i] && (IdxWidth'(i) >= ptr_q);
    end
  end

  lzc #(
    .Width   (NumIn),
    .Mode    (1'b0),
    .CntWidth(IdxWidth)
  ) u_lzc_masked (
    .vec  (mask),
    .cnt  (m_idx),
    .empty(m_empty)
  );

  lzc #(
    .Width   (NumIn),
    .Mode    (1'b0),
    .CntWidth(IdxWidth)
  ) u_lzc_full (
    .vec  (req_i),
    .cnt  (f_idx),
    .empty(f_empty)
  );

  // Wrap to the unmasked search only when nothing sits at or above ptr_q.
  assign sel = m_empty ? f_idx : m_idx;

  always_comb begin
    idx = sel;
    if (state_q == BURST) begin
      idx = owner_q;
    end else if (lock_q) begin
      idx = lock_idx_q;
    end
  end

  assign idx_o  = idx;
  assign req_o  = req_i[idx];
  assign last_o = last_i[idx];
  assign data_o = data_i[idx];
  assign busy_o = (state_q == BURST);

  assign hs  = req_o && gnt_i;
  assign lhs = hs && last_o;

  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < NumIn; i++) begin
      gnt_o[i] = hs && (idx == IdxWidth'(i));
    end
  end

  // Weight is only read on reload; a zero weight still grants one burst.
  assign wgt        = weight_i[ptr_q];
  assign eff_credit = (credit_q != '0) ? credit_q :
                      (wgt == '0) ? WeightWidth'(1) : wgt;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    ptr_d      = ptr_q;
    credit_d   = credit_q;

    unique case (state_q)
      IDLE: begin
        if (hs) begin
          lock_d = 1'b0;
        end else if (req_o) begin
          lock_d     = 1'b1;
          lock_idx_d = idx;
        end
        if (hs && !last_o) begin
          state_d = BURST;
          owner_d = idx;
        end
      end
      BURST: begin
        if (lhs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (lhs) begin
      if ((idx == ptr_q) && (eff_credit > WeightWidth'(1))) begin
        credit_d = eff_credit - WeightWidth'(1);
      end else begin
        credit_d = '0;
        ptr_d    = (idx == IdxWidth'(NumIn - 1)) ? '0 : idx + IdxWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      ptr_q      <= '0;
      credit_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      ptr_q      <= ptr_d;
      credit_q   <= credit_d;
    end
  end

  // A stalled IDLE request must stay up until it is served.
  lock_hold_a: assert property (
    @(posedge clk_i) disable iff (!rst_ni || clr_i)
    lock_q |-> req_i[lock_idx_q]
  );

  gnt_onehot_a: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt_o)
  );

endmodule

// File: tb/tb_burst_wrr_arb.sv
// Scoreboard bench for burst_wrr_arb (NumIn=4).
// Directed bursts push expected beats; a negedge monitor checks handshakes.
module tb_burst_wrr_arb;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic [3:0][3:0]  wt;
  logic [3:0]       req;
  logic [3:0]       last;
  logic [31:0]      data [4];
  logic [3:0]       gnt_o;
  logic             req_o;
  logic             last_o;
  logic [31:0]      data_o;
  logic [1:0]       idx_o;
  logic             gnt_in;
  logic             busy;
  logic [7:0]       beat;

  int tests;
  int fails;

  typedef struct {
    int          idx;
    logic        last;
    logic [31:0] data;
  } exp_t;

  exp_t q [$];

  burst_wrr_arb #(
    .NumIn      (4),
    .DataWidth  (32),
    .WeightWidth(4)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (clr),
    .weight_i(wt),
    .req_i   (req),
    .last_i  (last),
    .data_i  (data),
    .gnt_o   (gnt_o),
    .req_o   (req_o),
    .last_o  (last_o),
    .data_o  (data_o),
    .idx_o   (idx_o),
    .gnt_i   (gnt_in),
    .busy_o  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_data
    assign data[g] = {16'hC0DE, 8'(g), beat};
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    beat = beat + 8'd1;
  endtask

  task automatic expect_hs(input int i);
    exp_t e;
    e.idx  = i;
    e.last = last[i];
    e.data = {16'hC0DE, 8'(i), beat};
    q.push_back(e);
  endtask

  task automatic clear();
    req = 4'b0000;
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // Monitor: every downstream handshake must match the next queued beat.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !clr && req_o && gnt_in) begin
        if (q.size() == 0) begin
          chk("unexpected_hs_idx", 32'(idx_o), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("hs_idx", 32'(idx_o), 32'(e.idx));
          chk("hs_last", 32'(last_o), 32'(e.last));
          chk("hs_data", data_o, e.data);
          chk("hs_gnt", 32'(gnt_o), 32'(4'(1) << e.idx));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int seq_a [5] = '{0, 1, 2, 3, 0};
    int seq_b [5] = '{0, 0, 0, 1, 0};
    tests  = 0;
    fails  = 0;
    beat   = 8'd0;
    rst_n  = 1'b0;
    clr    = 1'b0;
    req    = 4'b0000;
    last   = 4'b0000;
    gnt_in = 1'b1;
    wt     = {4'd1, 4'd1, 4'd1, 4'd1};
    step();
    step();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_req_o", 32'(req_o), 0);
    chk("reset_gnt_o", 32'(gnt_o), 0);
    rst_n = 1'b1;

    // Equal weights, single-beat bursts: plain rotation.
    req  = 4'b1111;
    last = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      expect_hs(seq_a[k]);
      step();
    end
    clear();

    // Weight 3 on requester 0.
    wt[0] = 4'd3;
    req   = 4'b0011;
    last  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      expect_hs(seq_b[k]);
      step();
    end
    clear();
    wt[0] = 4'd1;

    // Move ptr to 2, then a 3-beat burst from 2 while 0 also requests.
    req  = 4'b0011;
    last = 4'b1111;
    expect_hs(0);
    step();
    expect_hs(1);
    step();
    req  = 4'b0101;
    last = 4'b0000;
    expect_hs(2);
    step();
    chk("burst_busy_b2", 32'(busy), 1);
    expect_hs(2);
    step();
    chk("burst_busy_b3", 32'(busy), 1);
    last[2] = 1'b1;
    expect_hs(2);
    step();
    chk("burst_done_busy", 32'(busy), 0);
    last = 4'b1111;
    expect_hs(0);
    step();
    clear();

    // Downstream stall: selection locked on 1 while 2 also requests.
    req  = 4'b0001;
    last = 4'b1111;
    expect_hs(0);
    step();
    req    = 4'b0110;
    gnt_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_idx", 32'(idx_o), 1);
      chk("stall_gnt", 32'(gnt_o), 0);
      step();
    end
    gnt_in = 1'b1;
    expect_hs(1);
    step();
    clear();

    // Reset in beat 2 of a burst from 3 abandons it.
    req  = 4'b1000;
    last = 4'b0000;
    expect_hs(3);
    step();
    req   = 4'b1011;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_idx", 32'(idx_o), 0);
    last = 4'b1111;
    expect_hs(0);
    step();
    clear();

    // Owner drops req mid-burst for 2 cycles; lock holds.
    req  = 4'b0001;
    last = 4'b0000;
    expect_hs(0);
    step();
    req = 4'b1110;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("gap_req_o", 32'(req_o), 0);
      chk("gap_gnt_o", 32'(gnt_o), 0);
      chk("gap_idx", 32'(idx_o), 0);
      chk("gap_busy", 32'(busy), 1);
      step();
    end
    req     = 4'b1111;
    last[0] = 1'b1;
    expect_hs(0);
    step();
    chk("resume_busy", 32'(busy), 0);
    last = 4'b1111;
    expect_hs(1);
    step();
    req = 4'b0000;
    step();
    step();

    chk("queue_empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
